// File: rtl/ir_key_event_ctrl.sv
// Key event controller behind the NEC IR decoder: press/hold/release events,
// saturating repeat counter, two-key display word and the key-held LED.
module ir_key_event_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int HOLD_MS  = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        is_repeat,
  output logic [15:0] disp_data,
  output logic        key_held,
  output logic        key_press,
  output logic        key_release,
  output logic [7:0]  repeat_cnt
);

  localparam int HOLD_CYC = (CLK_FREQ / 1000) * HOLD_MS;
  localparam int HW       = $clog2(HOLD_CYC + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic [15:0]   disp_nxt;
  logic [7:0]    cnt_nxt;
  logic          press_nxt;
  logic          release_nxt;
  logic          new_key;
  logic          rpt_key;

  assign new_key = data_valid & ~is_repeat;
  assign rpt_key = data_valid &  is_repeat;

  // Next-state and next-output decode; a strobe always beats hold expiry.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    disp_nxt    = disp_data;
    cnt_nxt     = repeat_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (new_key) begin
          disp_nxt  = {disp_data[7:0], data_in};
          cnt_nxt   = 8'd0;
          hold_nxt  = HW'(HOLD_CYC);
          press_nxt = 1'b1;
          state_nxt = HELD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HELD: begin
        if (new_key) begin
          disp_nxt  = {disp_data[7:0], data_in};
          cnt_nxt   = 8'd0;
          hold_nxt  = HW'(HOLD_CYC);
          press_nxt = 1'b1;
        end else if (rpt_key) begin
          cnt_nxt  = (repeat_cnt == 8'hFF) ? 8'hFF : repeat_cnt + 8'd1;
          hold_nxt = HW'(HOLD_CYC);
        end else if (hold_cnt <= HW'(1)) begin
          // Last cycle of the window: drop to IDLE and emit the release pulse.
          hold_nxt    = '0;
          release_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          hold_nxt = hold_cnt - HW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      disp_data   <= 16'h0000;
      repeat_cnt  <= 8'd0;
      key_held    <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      disp_data   <= disp_nxt;
      repeat_cnt  <= cnt_nxt;
      key_held    <= (state_nxt == HELD);
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

endmodule
